// File: rtl/pe_skew_feeder.sv
// Operand feeder for a systolic PE row: FIFO-buffered vectors issued with a per-lane diagonal skew,
// zero bubbles when starved and a zero flush at tile end. Optional macro PE_FEED_BUBBLE_CNT_EN adds o_bubble_cnt.
module pe_skew_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] s_tap,
    input  logic                            s_last,
    output logic [NUM_LANES*DATA_WIDTH-1:0] o_data,
    output logic [NUM_LANES*DATA_WIDTH-1:0] o_tap,
    output logic [NUM_LANES-1:0]            o_lane_valid,
    output logic                            o_tile_done,
    output logic                            o_busy
`ifdef PE_FEED_BUBBLE_CNT_EN
    ,
    output logic [15:0]                     o_bubble_cnt
`endif
);

    localparam int VW   = NUM_LANES * DATA_WIDTH;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int FCW  = $clog2(NUM_LANES + 2);
    localparam logic [CNTW-1:0] LP_FULL  = CNTW'(FIFO_DEPTH);
    localparam logic [FCW-1:0]  LP_FLUSH = FCW'(NUM_LANES + 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    logic [VW-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [VW-1:0]   r_fifo_tap  [FIFO_DEPTH];
    logic            r_fifo_last [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [FCW-1:0]  r_flush_cnt;
    logic [FCW-1:0]  w_flush_cnt_nxt;
    logic            r_tile_done;
    logic            w_done_nxt;

    logic            w_push;
    logic            w_pop;
    logic [VW-1:0]   w_head_data;
    logic [VW-1:0]   w_head_tap;
    logic            w_head_last;

    assign s_ready     = (r_count != LP_FULL);
    assign w_push      = s_valid & s_ready;
    assign w_pop       = (r_count != '0) && (r_state != FLUSH);
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_tap  = r_fifo_tap[r_rd_ptr];
    assign w_head_last = r_fifo_last[r_rd_ptr];

    // FIFO storage carries no reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= s_data;
            r_fifo_tap[r_wr_ptr]  <= s_tap;
            r_fifo_last[r_wr_ptr] <= s_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_done_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_nxt = w_head_last ? FLUSH : STREAM;
                    if (w_head_last) w_flush_cnt_nxt = LP_FLUSH;
                end
            end
            STREAM: begin
                if (w_pop && w_head_last) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = LP_FLUSH;
                end
            end
            FLUSH: begin
                w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
                if (r_flush_cnt == FCW'(1)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
            r_tile_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_tile_done <= w_done_nxt;
        end
    end

    assign o_tile_done = r_tile_done;
    assign o_busy      = (r_state != IDLE);

    // Lane i owns an (i+1)-deep delay line; element 0 is its slice of the lane-0 stage.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_dl [0:i];
        logic [DATA_WIDTH-1:0] r_tl [0:i];
        logic                  r_vl [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    r_dl[j] <= '0;
                    r_tl[j] <= '0;
                    r_vl[j] <= 1'b0;
                end
            end else begin
                r_dl[0] <= w_pop ? w_head_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                r_tl[0] <= w_pop ? w_head_tap[i*DATA_WIDTH +: DATA_WIDTH]  : '0;
                r_vl[0] <= w_pop;
                for (int j = 1; j <= i; j++) begin
                    r_dl[j] <= r_dl[j-1];
                    r_tl[j] <= r_tl[j-1];
                    r_vl[j] <= r_vl[j-1];
                end
            end
        end

        assign o_data[i*DATA_WIDTH +: DATA_WIDTH] = r_dl[i];
        assign o_tap[i*DATA_WIDTH +: DATA_WIDTH]  = r_tl[i];
        assign o_lane_valid[i]                    = r_vl[i];
    end

`ifdef PE_FEED_BUBBLE_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (r_state == IDLE && w_state_nxt != IDLE) begin
            r_bubble_cnt <= '0;
        end else if (r_state == STREAM && !w_pop) begin
            r_bubble_cnt <= sat_inc16(r_bubble_cnt);
        end
    end

    assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Directed self-checking bench for pe_skew_feeder (DATA_WIDTH=32, NUM_LANES=4, FIFO_DEPTH=4)
// with a simple registered multiply-accumulate PE model attached to each lane.
module tb_pe_skew_feeder;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic [127:0] s_tap;
    logic         s_last;
    logic [127:0] o_data;
    logic [127:0] o_tap;
    logic [3:0]   o_lane_valid;
    logic         o_tile_done;
    logic         o_busy;
`ifdef PE_FEED_BUBBLE_CNT_EN
    logic [15:0]  bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pe_skew_feeder #(
        .DATA_WIDTH(32),
        .NUM_LANES (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_tap       (s_tap),
        .s_last      (s_last),
        .o_data      (o_data),
        .o_tap       (o_tap),
        .o_lane_valid(o_lane_valid),
        .o_tile_done (o_tile_done),
        .o_busy      (o_busy)
`ifdef PE_FEED_BUBBLE_CNT_EN
        ,
        .o_bubble_cnt(bubble_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PE model: operand register then accumulator register, accumulating every cycle.
    logic [31:0] pe_d   [4];
    logic [31:0] pe_t   [4];
    logic [63:0] pe_acc [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pe_d[i]   <= '0;
                pe_t[i]   <= '0;
                pe_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                pe_d[i]   <= o_data[i*32 +: 32];
                pe_t[i]   <= o_tap[i*32 +: 32];
                pe_acc[i] <= pe_acc[i] + 64'(pe_d[i]) * 64'(pe_t[i]);
            end
        end
    end

    int lane_cnt [4] = '{0, 0, 0, 0};
    int done_cnt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) lane_cnt[i] <= lane_cnt[i] + int'(o_lane_valid[i]);
        done_cnt <= done_cnt + int'(o_tile_done);
    end

    function automatic logic [127:0] vec(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [127:0] rep(input logic [31:0] w);
        return {w, w, w, w};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lane0(input string tag, input logic [31:0] w);
        chk(tag, {o_lane_valid[0], o_data[31:0]}, {1'b1, w});
    endtask

    task automatic push(input logic [127:0] d, input logic [127:0] t, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_tap   = t;
        s_last  = l;
        n = 0;
        while (!s_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", s_ready, 1);
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!o_tile_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, o_tile_done, 1);
    endtask

    int snap [4];
    int snap_done;

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_tap   = '0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_data", o_data, 0);
        chk("rst_tap", o_tap, 0);
        chk("rst_lv", o_lane_valid, 0);
        chk("rst_done", o_tile_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", s_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single-vector tile: diagonal skew and flush timing.
        s_data  = vec(32'd1, 32'd2, 32'd3, 32'd4);
        s_tap   = rep(32'd1);
        s_last  = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("t2_busy_T0", o_busy, 0);
        chk("t2_lv_T0", o_lane_valid, 0);
        @(negedge clk);
        chk("t2_data_T1", o_data, vec(32'd1, 0, 0, 0));
        chk("t2_tap_T1", o_tap, vec(32'd1, 0, 0, 0));
        chk("t2_lv_T1", o_lane_valid, 4'b0001);
        chk("t2_busy_T1", o_busy, 1);
        @(negedge clk);
        chk("t2_data_T2", o_data, vec(0, 32'd2, 0, 0));
        chk("t2_lv_T2", o_lane_valid, 4'b0010);
        @(negedge clk);
        chk("t2_data_T3", o_data, vec(0, 0, 32'd3, 0));
        chk("t2_lv_T3", o_lane_valid, 4'b0100);
        @(negedge clk);
        chk("t2_data_T4", o_data, vec(0, 0, 0, 32'd4));
        chk("t2_tap_T4", o_tap, vec(0, 0, 0, 32'd1));
        chk("t2_lv_T4", o_lane_valid, 4'b1000);
        chk("t2_done_T4", o_tile_done, 0);
        @(negedge clk);
        chk("t2_lv_T5", o_lane_valid, 0);
        chk("t2_done_T5", o_tile_done, 0);
        chk("t2_busy_T5", o_busy, 1);
        @(negedge clk);
        chk("t2_done_T6", o_tile_done, 1);
        chk("t2_busy_T6", o_busy, 0);
        @(negedge clk);
        chk("t2_done_T7", o_tile_done, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Eight back-to-back vectors, data k+1, tap 2.
        for (int i = 0; i < 4; i++) snap[i] = lane_cnt[i];
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_data  = rep(32'(k + 1));
            s_tap   = rep(32'd2);
            s_last  = (k == 7);
            @(negedge clk);
            if (k >= 1) chk_lane0("t3_lane0_seq", 32'(k));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        chk_lane0("t3_lane0_last", 32'd8);
        wait_done("t3_done");
        for (int i = 0; i < 4; i++) chk("t3_pe_acc", pe_acc[i], 64'd72);
        for (int i = 0; i < 4; i++) chk("t3_lane_cnt", lane_cnt[i] - snap[i], 8);
`ifdef PE_FEED_BUBBLE_CNT_EN
        chk("t3_bubble_cnt", bubble_cnt, 0);
`endif

        // Source idles three cycles mid-tile.
        push(rep(32'h100), rep(32'd1), 1'b0);
        push(rep(32'h101), rep(32'd1), 1'b0);
        s_valid = 1'b0;
        chk_lane0("t4_v0", 32'h100);
        @(negedge clk);
        chk_lane0("t4_v1", 32'h101);
        @(negedge clk);
        chk("t4_bub1", {o_lane_valid[0], o_data[31:0]}, 0);
        chk("t4_busy1", o_busy, 1);
        @(negedge clk);
        chk("t4_bub2", {o_lane_valid[0], o_data[31:0]}, 0);
        push(rep(32'h102), rep(32'd1), 1'b0);
        chk("t4_bub3", {o_lane_valid[0], o_data[31:0]}, 0);
        chk("t4_busy3", o_busy, 1);
        push(rep(32'h103), rep(32'd1), 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk_lane0("t4_v2", 32'h102);
        @(negedge clk);
        chk_lane0("t4_v3", 32'h103);
        wait_done("t4_done");
`ifdef PE_FEED_BUBBLE_CNT_EN
        chk("t4_bubble_cnt", bubble_cnt, 3);
`endif

        // Fill the FIFO while the previous tile flushes.
        push(rep(32'h200), rep(32'd1), 1'b1);
        push(rep(32'h300), rep(32'd1), 1'b0);
        push(rep(32'h301), rep(32'd1), 1'b0);
        push(rep(32'h302), rep(32'd1), 1'b0);
        push(rep(32'h303), rep(32'd1), 1'b0);
        s_data  = rep(32'h304);
        s_last  = 1'b1;
        s_valid = 1'b1;
        chk("t5_full_C4", s_ready, 0);
        chk("t5_busy_C4", o_busy, 1);
        @(negedge clk);
        chk("t5_full_C5", s_ready, 0);
        @(negedge clk);
        chk("t5_full_C6", s_ready, 0);
        chk("t5_done_C6", o_tile_done, 1);
        @(negedge clk);
        chk("t5_ready_C7", s_ready, 1);
        chk_lane0("t5_w0", 32'h300);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk_lane0("t5_w1", 32'h301);
        @(negedge clk);
        chk_lane0("t5_w2", 32'h302);
        @(negedge clk);
        chk_lane0("t5_w3", 32'h303);
        @(negedge clk);
        chk_lane0("t5_w4", 32'h304);
        wait_done("t5_done");

        // Two tiles back to back, last on vectors 2 and 4.
        @(negedge clk);
        snap_done = done_cnt;
        push(rep(32'h401), rep(32'd1), 1'b0);
        push(rep(32'h402), rep(32'd1), 1'b1);
        push(rep(32'h403), rep(32'd1), 1'b0);
        push(rep(32'h404), rep(32'd1), 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("t6_gap_D3", o_lane_valid[0], 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t6_gap", o_lane_valid[0], 0);
        end
        chk("t6_done1", o_tile_done, 1);
        @(negedge clk);
        chk_lane0("t6_v3", 32'h403);
        chk("t6_done1_end", o_tile_done, 0);
        @(negedge clk);
        chk_lane0("t6_v4", 32'h404);
        wait_done("t6_done2");
        @(negedge clk);
        chk("t6_pulses", done_cnt - snap_done, 2);

        // Asynchronous reset in the middle of a tile.
        push(rep(32'h500), rep(32'd1), 1'b0);
        push(rep(32'h501), rep(32'd1), 1'b0);
        s_valid = 1'b0;
        chk("t1_busy_pre", o_busy, 1);
        chk_lane0("t1_lane0_pre", 32'h500);
        #2 rst = 1'b1;
        #1;
        chk("t1_data", o_data, 0);
        chk("t1_tap", o_tap, 0);
        chk("t1_lv", o_lane_valid, 0);
        chk("t1_done", o_tile_done, 0);
        chk("t1_busy", o_busy, 0);
        chk("t1_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_lv_after", o_lane_valid, 0);
        chk("t1_busy_after", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
